write_pointer_sync: RTL and testbench

//  Write-domain pointer controller for a dual-clock FIFO, fully parametrised in address width.

---
 rtl/write_pointer_sync_if.sv | 28 ++
 rtl/write_pointer_sync.sv | 104 ++++++++++
 tb/tb_write_pointer_sync.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/write_pointer_sync_if.sv
// Signal bundle between a FIFO write-side client and its write-pointer controller.
// Widths follow ADDRESS_WIDTH; pointers carry one extra wrap bit.
interface write_pointer_sync_if #(
    parameter int ADDRESS_WIDTH = 4
);
    logic                     increment;
    logic                     clear_overflow;
    logic [ADDRESS_WIDTH:0]   read_pointer_gray;
    logic                     write_enable;
    logic [ADDRESS_WIDTH-1:0] write_address;
    logic [ADDRESS_WIDTH:0]   write_pointer_gray;
    logic                     full;
    logic                     almost_full;
    logic [ADDRESS_WIDTH:0]   fill_level;
    logic                     overflow;

    modport master (
        output increment, clear_overflow, read_pointer_gray,
        input  write_enable, write_address, write_pointer_gray,
        input  full, almost_full, fill_level, overflow
    );

    modport slave (
        input  increment, clear_overflow, read_pointer_gray,
        output write_enable, write_address, write_pointer_gray,
        output full, almost_full, fill_level, overflow
    );
endinterface

// File: rtl/write_pointer_sync.sv
// Write-domain pointer controller for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser and registered full / almost_full / fill_level / overflow.
module write_pointer_sync #(
    parameter int ADDRESS_WIDTH     = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                clock,
    input  logic                reset_n,
    write_pointer_sync_if.slave bus
);
    localparam int PW    = ADDRESS_WIDTH + 1;
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
    localparam ptr_t AF_LEVEL = ptr_t'(ALMOST_FULL_LEVEL);

    generate
        if (ADDRESS_WIDTH < 1) begin : g_bad_aw
            $error("write_pointer_sync: ADDRESS_WIDTH must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("write_pointer_sync: SYNC_STAGES must be >= 2");
        end
        if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
            $error("write_pointer_sync: ALMOST_FULL_LEVEL must be in 1..DEPTH");
        end
    endgenerate

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
    ptr_t wp_q, wp_d;
    ptr_t wp_gray_q, wp_gray_d;
    ptr_t fill_q, fill_d;
    logic full_q, full_d;
    logic almost_full_q, almost_full_d;
    logic overflow_q, overflow_d;
    ptr_t rp_sync_next;
    logic write_enable;

    // Only combinational output: gated by the registered full, never by the fresh count.
    assign write_enable = bus.increment & ~full_q;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.read_pointer_gray;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Flags are computed from next-state values so they always match the current wp and rp_sync.
    always_comb begin
        rp_sync_next  = gray2bin(sync_d[SYNC_STAGES-1]);
        wp_d          = wp_q + ptr_t'(write_enable);
        wp_gray_d     = bin2gray(wp_d);
        fill_d        = wp_d - rp_sync_next;
        full_d        = (fill_d == DEPTH_P);
        almost_full_d = (fill_d >= AF_LEVEL);
        overflow_d    = (bus.increment & full_q) | (overflow_q & ~bus.clear_overflow);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            wp_q          <= '0;
            wp_gray_q     <= '0;
            fill_q        <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            wp_q          <= wp_d;
            wp_gray_q     <= wp_gray_d;
            fill_q        <= fill_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.write_enable       = write_enable;
    assign bus.write_address      = wp_q[ADDRESS_WIDTH-1:0];
    assign bus.write_pointer_gray = wp_gray_q;
    assign bus.full               = full_q;
    assign bus.almost_full        = almost_full_q;
    assign bus.fill_level         = fill_q;
    assign bus.overflow           = overflow_q;
endmodule

// File: tb/tb_write_pointer_sync.sv
// Bench for write_pointer_sync: two configurations side by side, a history-based
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_write_pointer_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       inc [2];
    logic       clr [2];
    logic [6:0] rpb [2];

    logic [6:0] o_addr [2], o_gray [2], o_fill [2];
    logic       o_we [2], o_full [2], o_af [2], o_ov [2];

    int AW  [2] = '{4, 6};
    int SS  [2] = '{2, 3};
    int AF  [2] = '{12, 60};
    int D   [2] = '{16, 64};
    int MOD [2] = '{32, 128};
    int GFULL [2] = '{24, 96};
    int NWR4  [2] = '{40, 140};

    int n_vec = 0;
    int n_err = 0;

    write_pointer_sync_if #(.ADDRESS_WIDTH(4)) bus0 ();
    write_pointer_sync_if #(.ADDRESS_WIDTH(6)) bus1 ();

    write_pointer_sync #(.ADDRESS_WIDTH(4), .SYNC_STAGES(2), .ALMOST_FULL_LEVEL(12)) dut0 (
        .clock(clk), .reset_n(reset_n), .bus(bus0));
    write_pointer_sync #(.ADDRESS_WIDTH(6), .SYNC_STAGES(3), .ALMOST_FULL_LEVEL(60)) dut1 (
        .clock(clk), .reset_n(reset_n), .bus(bus1));

    assign bus0.increment         = inc[0];
    assign bus0.clear_overflow    = clr[0];
    assign bus0.read_pointer_gray = 5'(rpb[0] ^ (rpb[0] >> 1));
    assign bus1.increment         = inc[1];
    assign bus1.clear_overflow    = clr[1];
    assign bus1.read_pointer_gray = 7'(rpb[1] ^ (rpb[1] >> 1));

    assign o_we[0]   = bus0.write_enable;
    assign o_addr[0] = 7'(bus0.write_address);
    assign o_gray[0] = 7'(bus0.write_pointer_gray);
    assign o_full[0] = bus0.full;
    assign o_af[0]   = bus0.almost_full;
    assign o_fill[0] = 7'(bus0.fill_level);
    assign o_ov[0]   = bus0.overflow;
    assign o_we[1]   = bus1.write_enable;
    assign o_addr[1] = 7'(bus1.write_address);
    assign o_gray[1] = 7'(bus1.write_pointer_gray);
    assign o_full[1] = bus1.full;
    assign o_af[1]   = bus1.almost_full;
    assign o_fill[1] = 7'(bus1.fill_level);
    assign o_ov[1]   = bus1.overflow;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: write count, plus a history of the binary read pointer presented
    // at each edge; rp_sync is the value presented SYNC_STAGES-1 edges ago.
    int m_wp [2], m_fill [2];
    bit m_full [2], m_af [2], m_ov [2];
    int hist [2][8];

    function automatic int nwp(input int c);
        return (m_wp[c] + ((inc[c] && !m_full[c]) ? 1 : 0)) % MOD[c];
    endfunction

    function automatic int nfill(input int c);
        return (nwp(c) - hist[c][SS[c]-2] + MOD[c]) % MOD[c];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                m_wp[c] <= 0; m_fill[c] <= 0; m_full[c] <= 0; m_af[c] <= 0; m_ov[c] <= 0;
                for (int k = 0; k < 8; k++) hist[c][k] <= 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_wp[c]   <= nwp(c);
                m_fill[c] <= nfill(c);
                m_full[c] <= (nfill(c) == D[c]);
                m_af[c]   <= (nfill(c) >= AF[c]);
                m_ov[c]   <= (inc[c] && m_full[c]) || (m_ov[c] && !clr[c]);
                hist[c][0] <= int'(rpb[c]);
                for (int k = 1; k < 8; k++) hist[c][k] <= hist[c][k-1];
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("c%0d model write_enable", c), int'(o_we[c]), int'(inc[c] && !m_full[c]));
                chk($sformatf("c%0d model write_address", c), int'(o_addr[c]), m_wp[c] % D[c]);
                chk($sformatf("c%0d model write_pointer_gray", c), int'(o_gray[c]), m_wp[c] ^ (m_wp[c] >> 1));
                chk($sformatf("c%0d model full", c), int'(o_full[c]), int'(m_full[c]));
                chk($sformatf("c%0d model almost_full", c), int'(o_af[c]), int'(m_af[c]));
                chk($sformatf("c%0d model fill_level", c), int'(o_fill[c]), m_fill[c]);
                chk($sformatf("c%0d model overflow", c), int'(o_ov[c]), int'(m_ov[c]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            inc[c] = 1'b0; clr[c] = 1'b0; rpb[c] = '0;
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_to_full(input int c);
        do_reset();
        chk($sformatf("c%0d reset fill_level", c), int'(o_fill[c]), 0);
        chk($sformatf("c%0d reset write_pointer_gray", c), int'(o_gray[c]), 0);
        inc[c] = 1'b1;
        for (int i = 0; i < D[c] + 4; i++) begin
            #1;
            chk($sformatf("c%0d t1 write_enable[%0d]", c, i), int'(o_we[c]), (i < D[c]) ? 1 : 0);
            if (i < D[c]) chk($sformatf("c%0d t1 write_address[%0d]", c, i), int'(o_addr[c]), i);
            tick();
        end
        chk($sformatf("c%0d t1 full", c), int'(o_full[c]), 1);
        chk($sformatf("c%0d t1 fill_level", c), int'(o_fill[c]), D[c]);
        chk($sformatf("c%0d t1 write_pointer_gray", c), int'(o_gray[c]), GFULL[c]);
        chk($sformatf("c%0d t1 write_enable", c), int'(o_we[c]), 0);
        chk($sformatf("c%0d t1 overflow", c), int'(o_ov[c]), 1);
        inc[c] = 1'b0;
        tick();
    endtask

    task automatic test_thresholds_and_drain(input int c);
        do_reset();
        inc[c] = 1'b1;
        for (int k = 1; k <= D[c]; k++) begin
            tick();
            chk($sformatf("c%0d t2 fill_level@%0d", c, k), int'(o_fill[c]), k);
            chk($sformatf("c%0d t2 full@%0d", c, k), int'(o_full[c]), (k == D[c]) ? 1 : 0);
            if (k == AF[c] - 1) chk($sformatf("c%0d t2 almost_full below", c), int'(o_af[c]), 0);
            if (k == AF[c])     chk($sformatf("c%0d t2 almost_full at", c), int'(o_af[c]), 1);
        end
        inc[c] = 1'b0;
        tick();
        rpb[c] = 7'd4;
        for (int k = 1; k <= SS[c]; k++) begin
            tick();
            chk($sformatf("c%0d t3 full after %0d edges", c, k), int'(o_full[c]), (k < SS[c]) ? 1 : 0);
            chk($sformatf("c%0d t3 fill after %0d edges", c, k), int'(o_fill[c]),
                (k < SS[c]) ? D[c] : D[c] - 4);
        end
        inc[c] = 1'b1;
        #1;
        chk($sformatf("c%0d t3 write_enable after drain", c), int'(o_we[c]), 1);
        tick();
        inc[c] = 1'b0;
        tick();
    endtask

    task automatic test_wrap(input int c);
        logic [6:0] prev_gray;
        int rp;
        do_reset();
        prev_gray = o_gray[c];
        for (int m = 1; m <= NWR4[c]; m++) begin
            inc[c] = 1'b1;
            rp = m + SS[c] - 4;
            rpb[c] = 7'((rp < 0) ? 0 : rp % MOD[c]);
            tick();
            chk($sformatf("c%0d t4 gray one-bit step %0d", c, m), $countones(o_gray[c] ^ prev_gray), 1);
            prev_gray = o_gray[c];
            if (m >= 3) chk($sformatf("c%0d t4 fill_level %0d", c, m), int'(o_fill[c]), 3);
            if (m == MOD[c]) chk($sformatf("c%0d t4 gray after wrap", c), int'(o_gray[c]), 0);
        end
        inc[c] = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            inc[c] = 1'b0; clr[c] = 1'b0; rpb[c] = '0;
        end
        for (int c = 0; c < 2; c++) begin
            test_fill_to_full(c);
            test_thresholds_and_drain(c);
            test_wrap(c);
        end

        // Overflow: set wins over a simultaneous clear, a lone clear takes effect.
        do_reset();
        inc[0] = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("t5 overflow set", int'(o_ov[0]), 1);
        clr[0] = 1'b1;
        tick();
        chk("t5 overflow set beats clear", int'(o_ov[0]), 1);
        inc[0] = 1'b0;
        tick();
        chk("t5 overflow cleared", int'(o_ov[0]), 0);
        clr[0] = 1'b0;
        tick();

        // Asynchronous reset mid-operation, then first write restarts at address 0.
        do_reset();
        inc[0] = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        inc[0] = 1'b0;
        tick();
        chk("t6 fill before reset", int'(o_fill[0]), 7);
        #1 reset_n = 1'b0;
        #1;
        chk("t6 async write_address", int'(o_addr[0]), 0);
        chk("t6 async gray", int'(o_gray[0]), 0);
        chk("t6 async fill", int'(o_fill[0]), 0);
        chk("t6 async full", int'(o_full[0]), 0);
        chk("t6 async almost_full", int'(o_af[0]), 0);
        chk("t6 async overflow", int'(o_ov[0]), 0);
        chk("t6 async write_enable", int'(o_we[0]), 0);
        tick();
        reset_n = 1'b1;
        tick();
        inc[0] = 1'b1;
        #1;
        chk("t6 first write_address", int'(o_addr[0]), 0);
        chk("t6 first write_enable", int'(o_we[0]), 1);
        tick();
        inc[0] = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
